// File: rtl/branch_pkg.sv
// Shared types and constants for the ID-stage branch resolution controller.
package branch_pkg;

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        RESOLVE  = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    localparam logic OP_BEQ = 1'b0;
    localparam logic OP_BNE = 1'b1;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch compare, taken decision and target adder.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [WIDTH-1:0] pc4,
    input  logic [15:0]      imm,
    output logic             taken_c,
    output logic [WIDTH-1:0] target_c
);

    logic             eq;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] offset;

    assign eq       = (rs == rt);
    assign taken_c  = (op == OP_BEQ) ? eq : !eq;
    assign imm_ext  = {{(WIDTH-16){imm[15]}}, imm};
    // Word offset to byte offset; the add wraps modulo 2^WIDTH by design.
    assign offset   = {imm_ext[WIDTH-3:0], 2'b00};
    assign target_c = pc4 + offset;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Releases the ID-stage branch hold: waits for operands, resolves, issues a one-cycle redirect.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             beqID,
    input  logic             bneID,
    input  logic             opReady,
    input  logic [WIDTH-1:0] rsVal,
    input  logic [WIDTH-1:0] rtVal,
    input  logic [WIDTH-1:0] pcPlus4ID,
    input  logic [15:0]      immID,
    output logic             branchDone,
    output logic             pcSrc,
    output logic [WIDTH-1:0] branchTarget,
    output logic             IFIDflush,
    output logic             busy,
    output logic [CNT_W-1:0] brCount,
    output logic [CNT_W-1:0] takenCount
);

    state_t           state;
    state_t           state_nxt;
    logic             ctx_load;
    logic             ops_load;
    logic             done_nxt;
    logic             op_q;
    logic [WIDTH-1:0] pc4_q;
    logic [15:0]      imm_q;
    logic [WIDTH-1:0] rs_q;
    logic [WIDTH-1:0] rt_q;
    logic             taken_c;
    logic [WIDTH-1:0] target_c;

    branch_cmp #(.WIDTH(WIDTH)) u_cmp (
        .op       (op_q),
        .rs       (rs_q),
        .rt       (rt_q),
        .pc4      (pc4_q),
        .imm      (imm_q),
        .taken_c  (taken_c),
        .target_c (target_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Branch inputs are only looked at in IDLE; the hold keeps the same instruction in ID.
    always_comb begin
        state_nxt = state;
        ctx_load  = 1'b0;
        ops_load  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (beqID || bneID) begin
                    ctx_load = 1'b1;
                    if (opReady) begin
                        ops_load  = 1'b1;
                        state_nxt = RESOLVE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (opReady) begin
                    ops_load  = 1'b1;
                    state_nxt = RESOLVE;
                end
            end
            RESOLVE: begin
                done_nxt  = 1'b1;
                state_nxt = REDIRECT;
            end
            REDIRECT: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Branch context and operand latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_BEQ;
            pc4_q <= '0;
            imm_q <= '0;
            rs_q  <= '0;
            rt_q  <= '0;
        end else begin
            if (ctx_load) begin
                op_q  <= beqID ? OP_BEQ : OP_BNE;
                pc4_q <= pcPlus4ID;
                imm_q <= immID;
            end
            if (ops_load) begin
                rs_q <= rsVal;
                rt_q <= rtVal;
            end
        end
    end

    // Registered outputs; the redirect pulse is live only in the REDIRECT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branchDone   <= 1'b0;
            pcSrc        <= 1'b0;
            IFIDflush    <= 1'b0;
            busy         <= 1'b0;
            branchTarget <= '0;
        end else begin
            branchDone <= done_nxt;
            pcSrc      <= done_nxt && taken_c;
            IFIDflush  <= done_nxt && taken_c;
            busy       <= (state_nxt != IDLE);
            if (done_nxt) branchTarget <= target_c;
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brCount    <= '0;
            takenCount <= '0;
        end else if (branchDone) begin
            if (brCount != '1) brCount <= brCount + CNT_W'(1);
            if (pcSrc && (takenCount != '1)) takenCount <= takenCount + CNT_W'(1);
        end
    end
`else
    assign brCount    = '0;
    assign takenCount = '0;
`endif

endmodule

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Branch resolution controller for the pipelined CPU. It is the release side of the ID-stage branch hold: while PC and IF/ID are frozen for a `beq`/`bne` in ID, this block waits for valid operands, compares them and computes the target. It then issues a single-cycle redirect/release pulse that tells the fetch stage where to resume and whether to flush IF/ID.

## Interface
Parameters:
- `WIDTH`, 32: data and PC width in bits.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `beqID` in 1: `beq` decoded in ID, same signal that raises the PC/IF-ID hold.
- `bneID` in 1: `bne` decoded in ID.
- `opReady` in 1: forwarding/hazard logic reports that `rsVal`/`rtVal` are valid this cycle.
- `rsVal` in WIDTH: first compare operand.
- `rtVal` in WIDTH: second compare operand.
- `pcPlus4ID` in WIDTH: PC+4 of the branch.
- `immID` in 16: raw branch offset, in words.
- `branchDone` out 1: one-cycle pulse ending the hold.
- `pcSrc` out 1: 1 selects `branchTarget` for the next PC; valid only with `branchDone`.
- `branchTarget` out WIDTH: computed target.
- `IFIDflush` out 1: flush IF/ID; equals `pcSrc` during `branchDone`.
- `busy` out 1: high in any state other than IDLE.
- `brCount` out 32: statistics counter (see Configuration).
- `takenCount` out 32: statistics counter (see Configuration).

## Operation
- FSM states: IDLE, WAIT, RESOLVE, REDIRECT.
- IDLE:
  - With `beqID|bneID` set: latch op type, `pcPlus4ID` and `immID`.
  - If `opReady` is also set, latch the operands and go to RESOLVE; otherwise go to WAIT.
- WAIT: hold until `opReady`, then latch the operands and go to RESOLVE. The wait has no timeout.
- RESOLVE:
  - `eq = (rs == rt)`; `taken = beq ? eq : !eq`.
  - `target = pc4 + {sext(imm), 2'b00}`, computed modulo 2^WIDTH; wrap-around is legal and not flagged.
  - Register the results, then go to REDIRECT.
- REDIRECT: drive `branchDone=1`, `pcSrc=taken`, `IFIDflush=taken`, `branchTarget=target`; return to IDLE.
- `beqID` and `bneID` both high: treated as `beq`.
- `beqID`/`bneID` in any non-IDLE state: ignored, because the hold keeps the same instruction in ID.
- Operand and branch inputs are not re-sampled after latching.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: `branchDone`, `pcSrc`, `IFIDflush`, `busy` = 0; `branchTarget` = 0; counters = 0.
- Latency, with `opReady` high when the branch is sampled in cycle N: RESOLVE in N+1, `branchDone` in N+2.
- Each WAIT cycle adds one cycle of latency.
- All outputs are registered; no combinational path from inputs to outputs.
- `branchDone`, `pcSrc` and `IFIDflush` are high for exactly one cycle per branch.
- `busy` is high from cycle N+1 up to and including the REDIRECT cycle.
- Returning from REDIRECT: IDLE is entered the cycle after REDIRECT. A branch present in that IDLE cycle is sampled then, so at most one `branchDone` every 3 cycles.
- Reset asserted mid-operation: FSM returns to IDLE and all pulses are cleared immediately (asynchronous); no redirect is issued for the aborted branch.

## Configuration
- `BRANCH_STATS_EN` defined:
  - `brCount` increments on every `branchDone`.
  - `takenCount` increments on every `branchDone` with `pcSrc`.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- `BRANCH_STATS_EN` undefined: counter logic is not built; `brCount` and `takenCount` are tied to 0.

## Structure
- Shared package `branch_pkg`:
  - FSM state typedef with 2-bit encoding IDLE=0, WAIT=1, RESOLVE=2, REDIRECT=3.
  - Op-type constants `OP_BEQ`/`OP_BNE`.
  - Localparam for the counter width (32).
- Sub-module `branch_cmp`: purely combinational equality compare, taken decision and target adder. Instantiated once; the FSM registers its outputs.

## Test plan
- `beq` taken: `beqID=1`, `opReady=1`, rs=rt=5, `pcPlus4ID=0x100`, imm=3 -> cycle N+2: `branchDone=1`, `pcSrc=1`, `IFIDflush=1`, target=0x10C.
- `bne` not taken: `bneID=1`, rs=rt=7 -> N+2: `branchDone=1`, `pcSrc=0`, `IFIDflush=0`.
- Operand stall: `beqID=1`, `opReady` low for 3 cycles -> `busy` high, `branchDone` appears 2 cycles after `opReady` rises; operand changes while waiting before `opReady` do not affect the result.
- Negative offset and wrap:
  - `pcPlus4ID=0x8`, imm=0xFFFC -> target=0xFFFFFFF8.
  - `pcPlus4ID=0xFFFFFFFC`, imm=1 -> target=0x0.
- Reset in RESOLVE: `rst_n` low -> all outputs 0 the same cycle, no `branchDone` after release; with `BRANCH_STATS_EN`, counters are 0.
- Back-to-back branches: 3 branches, 2 taken, with `BRANCH_STATS_EN` -> `brCount=3`, `takenCount=2`; at most one `branchDone` every 3 cycles.
